// File: rtl/alu_sll_unit_pkg.sv
// Shared ALU definitions: datapath width, shift-amount width and the
// function-select encoding used by the parent ALU result mux.
package alu_sll_unit_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SHAMT_W = $clog2(ALU_XLEN);

    typedef enum logic [3:0] {
        ALU_FN_ADD  = 4'h0,
        ALU_FN_SUB  = 4'h1,
        ALU_FN_SLL  = 4'h2,
        ALU_FN_SLT  = 4'h3,
        ALU_FN_SLTU = 4'h4,
        ALU_FN_XOR  = 4'h5,
        ALU_FN_SRL  = 4'h6,
        ALU_FN_SRA  = 4'h7,
        ALU_FN_OR   = 4'h8,
        ALU_FN_AND  = 4'h9
    } alu_fn_e;

endpackage

// File: rtl/alu_sll_unit_barrel.sv
// Logarithmic left barrel shifter: stage k shifts by 2^k when shamt[k] is set.
module sll_barrel_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] stage [0:SHAMT_W];

    assign stage[0] = data;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        assign stage[k+1] = shamt[k] ? (stage[k] << (2**k)) : stage[k];
    end

    assign result = stage[SHAMT_W];

endmodule

// File: rtl/alu_sll_unit.sv
// SLL/SLLI function unit: combinational result for the ALU mux plus a
// registered copy with a valid flag for pipelined consumers.
module alu_sll_unit
    import alu_sll_unit_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] rd,
    output logic [XLEN-1:0] rd_q,
    output logic            out_valid
);

    logic [SHAMT_W-1:0] shamt;
    logic               unused_rs2_hi;

    // Only the low shift-amount bits are tapped, so X/garbage above them never reaches rd.
    assign shamt         = rs2[SHAMT_W-1:0];
    assign unused_rs2_hi = ^rs2[XLEN-1:SHAMT_W];

    sll_barrel_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data   (rs1),
        .shamt  (shamt),
        .result (rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                rd_q <= rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_sll_unit.sv
// Self-checking bench for alu_sll_unit: directed cases plus randomized traffic
// against an arithmetic reference (rs1 * 2^(rs2 mod 32), truncated).
module tb_alu_sll_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic [31:0] rd_q;
    logic        out_valid;

    int total;
    int bad;

    logic [31:0] exp_q;
    logic        exp_v;

    alu_sll_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rd_q      (rd_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        int unsigned     amt;
        amt  = b % 32;
        prod = longint'(a) * (64'd1 << amt);
        return prod[31:0];
    endfunction

    // Drive at negedge, check rd, then check the registered outputs after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v, input string tag);
        logic [31:0] e;
        @(negedge clk);
        rs1      = a;
        rs2      = b;
        in_valid = v;
        #1;
        e = ref_sll(a, b);
        chk({tag, ".rd"}, rd, e);
        @(posedge clk);
        #1;
        if (v) exp_q = e;
        exp_v = v;
        chk({tag, ".rd_q"}, rd_q, exp_q);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_v});
    endtask

    initial begin
        logic [32:0] wide;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rs1      = '0;
        rs2      = '0;
        exp_q    = '0;
        exp_v    = 1'b0;

        #12;
        chk("reset.rd_q", rd_q, 32'h0);
        chk("reset.out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h0, 32'h0, 1'b1, "zero");
        chk("zero.rd_q_const", rd_q, 32'h0);
        step(32'h1, 32'd1, 1'b1, "one_by_one");
        step(32'hFFFF_FFFF, 32'd3, 1'b1, "ones_by_3");
        step(32'h1, 32'd31, 1'b1, "one_by_31");
        chk("one_by_31.const", rd_q, 32'h8000_0000);
        step(32'h1, 32'd33, 1'b1, "mask33");
        chk("mask33.const", rd_q, 32'h2);
        step(32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b1, "mask_hi");
        chk("mask_hi.const", rd_q, 32'hDEAD_BEEF);
        wide = 33'h1_0000_0000;
        step(wide[31:0], 32'd1, 1'b1, "trunc33");
        step(32'h8000_0001, 32'd1, 1'b1, "msb_drop");
        chk("msb_drop.const", rd_q, 32'h0000_0002);

        step(32'h1, 32'd4, 1'b1, "pipe0");
        chk("pipe0.const", rd_q, 32'h10);
        step(32'h3, 32'd2, 1'b1, "pipe1");
        chk("pipe1.const", rd_q, 32'hC);
        step(32'hF, 32'd28, 1'b1, "pipe2");
        chk("pipe2.const", rd_q, 32'hF000_0000);
        step(32'h1234_5678, 32'd7, 1'b0, "pipe_idle");
        chk("pipe_idle.hold", rd_q, 32'hF000_0000);

        // Async reset mid-cycle while a result is held and valid.
        step(32'h0000_00A5, 32'd8, 1'b1, "pre_rst");
        @(negedge clk);
        rs1      = 32'h3;
        rs2      = 32'd4;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.rd_q", rd_q, 32'h0);
        chk("async.out_valid", {31'b0, out_valid}, 32'h0);
        chk("async.rd_live", rd, 32'h30);
        @(posedge clk);
        #1;
        chk("rst_hold.rd_q", rd_q, 32'h0);
        chk("rst_hold.out_valid", {31'b0, out_valid}, 32'h0);
        exp_q = '0;
        exp_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h5, 32'd2, 1'b1, "post_rst");
        chk("post_rst.const", rd_q, 32'h14);

        for (int i = 0; i < 300; i++) begin
            step($urandom, $urandom, 1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
